// File: rtl/id_ex_if.sv
// ID/EX stage boundary: ID-side operands and control, forwarding taps from
// EX/MEM and MEM/WB, and the EX-side operand/control outputs.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // ID side
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_read_data_1;
  logic [DATA_W-1:0] id_read_data_2;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [3:0]        id_alu_control;
  logic              id_reg_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              flush;

  // Forwarding sources
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_dest;
  logic [DATA_W-1:0] exmem_alu_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_dest;
  logic [DATA_W-1:0] memwb_wb_data;

  // EX side
  logic              stall_id;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] mux_alu_src;
  logic [3:0]        control_input;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_read_data_1, id_read_data_2,
           id_imm, id_alu_src, id_alu_control, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_dest, exmem_alu_result,
           memwb_reg_write, memwb_dest, memwb_wb_data,
    input  stall_id, read_data_1, mux_alu_src, control_input, ex_store_data,
           ex_dest, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_read_data_1, id_read_data_2,
           id_imm, id_alu_src, id_alu_control, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, flush,
           exmem_reg_write, exmem_dest, exmem_alu_result,
           memwb_reg_write, memwb_dest, memwb_wb_data,
    output stall_id, read_data_1, mux_alu_src, control_input, ex_store_data,
           ex_dest, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use stall detection for the 5-stage MIPS core.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic    clk,
  input logic    reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  ctrl_t             ex_ctrl;
  logic              ex_alu_src;
  logic [3:0]        ex_alu_control;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest_q;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;

  logic              stall;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // rt is always treated as a source, even for I-type, to keep the detector simple.
  assign stall = ex_ctrl.valid & ex_ctrl.mem_read & (ex_dest_q != '0) &
                 bus.id_valid & ((ex_dest_q == bus.id_rs) | (ex_dest_q == bus.id_rt));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl        <= '0;
      ex_alu_src     <= 1'b0;
      ex_alu_control <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_dest_q      <= '0;
      ex_rd1         <= '0;
      ex_rd2         <= '0;
      ex_imm         <= '0;
    end else if (bus.flush || stall) begin
      // Bubble: kill control only; data fields keep their old values.
      ex_ctrl <= '0;
    end else begin
      ex_ctrl.valid      <= bus.id_valid;
      ex_ctrl.reg_write  <= bus.id_valid & bus.id_reg_write;
      ex_ctrl.mem_read   <= bus.id_valid & bus.id_mem_read;
      ex_ctrl.mem_write  <= bus.id_valid & bus.id_mem_write;
      ex_ctrl.mem_to_reg <= bus.id_mem_to_reg;
      ex_alu_src         <= bus.id_alu_src;
      ex_alu_control     <= bus.id_alu_control;
      ex_rs              <= bus.id_rs;
      ex_rt              <= bus.id_rt;
      ex_dest_q          <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      ex_rd1             <= bus.id_read_data_1;
      ex_rd2             <= bus.id_read_data_2;
      ex_imm             <= bus.id_imm;
    end
  end

  // NOTE: each output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fwd_a = ex_rd1;
    if (bus.exmem_reg_write && bus.exmem_dest != '0 && bus.exmem_dest == ex_rs)
      fwd_a = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && bus.memwb_dest != '0 && bus.memwb_dest == ex_rs)
      fwd_a = bus.memwb_wb_data;

    fwd_b = ex_rd2;
    if (bus.exmem_reg_write && bus.exmem_dest != '0 && bus.exmem_dest == ex_rt)
      fwd_b = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && bus.memwb_dest != '0 && bus.memwb_dest == ex_rt)
      fwd_b = bus.memwb_wb_data;
  end

  assign bus.stall_id      = stall;
  assign bus.read_data_1   = fwd_a;
  assign bus.ex_store_data = fwd_b;
  assign bus.mux_alu_src   = ex_alu_src ? ex_imm : fwd_b;
  assign bus.control_input = ex_alu_control;
  assign bus.ex_dest       = ex_dest_q;
  assign bus.ex_valid      = ex_ctrl.valid;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: an instruction-level model of the EX
// slot checked every cycle, plus directed hand-computed expectations.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: the instruction occupying EX ----------------
  typedef struct {
    bit          valid, rw, mr, mw, m2r, imm_op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b, imm;
    logic [3:0]  code;
  } ex_t;

  ex_t m;
  bit  model_ok = 0;

  function automatic bit model_stall();
    return m.valid && m.mr && m.dest != 0 && bus.id_valid &&
           (m.dest == bus.id_rs || m.dest == bus.id_rt);
  endfunction

  // Youngest in-flight writer of a nonzero register supplies the value.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (bus.exmem_reg_write && bus.exmem_dest == r) return bus.exmem_alu_result;
    if (bus.memwb_reg_write && bus.memwb_dest == r) return bus.memwb_wb_data;
    return rf;
  endfunction

  always @(posedge clk) begin
    ex_t n;
    n = m;
    if (reset) begin
      n = '{default: 0};
      model_ok <= 1;
    end else if (bus.flush || model_stall()) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
    end else begin
      n.valid  = bus.id_valid;
      n.rw     = bus.id_valid && bus.id_reg_write;
      n.mr     = bus.id_valid && bus.id_mem_read;
      n.mw     = bus.id_valid && bus.id_mem_write;
      n.m2r    = bus.id_mem_to_reg;
      n.imm_op = bus.id_alu_src;
      n.rs     = bus.id_rs;
      n.rt     = bus.id_rt;
      n.dest   = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      n.a      = bus.id_read_data_1;
      n.b      = bus.id_read_data_2;
      n.imm    = bus.id_imm;
      n.code   = bus.id_alu_control;
    end
    m <= n;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_stall",      32'(bus.stall_id),      32'(model_stall()));
      check("m_opA",        bus.read_data_1,        operand(m.rs, m.a));
      check("m_store",      bus.ex_store_data,      operand(m.rt, m.b));
      check("m_opB",        bus.mux_alu_src,        m.imm_op ? m.imm : operand(m.rt, m.b));
      check("m_code",       32'(bus.control_input), 32'(m.code));
      check("m_dest",       32'(bus.ex_dest),       32'(m.dest));
      check("m_valid",      32'(bus.ex_valid),      32'(m.valid));
      check("m_reg_write",  32'(bus.ex_reg_write),  32'(m.rw));
      check("m_mem_read",   32'(bus.ex_mem_read),   32'(m.mr));
      check("m_mem_write",  32'(bus.ex_mem_write),  32'(m.mw));
      check("m_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m.m2r));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, rt, rd, input logic [31:0] rd1, rd2, imm,
                        input logic alu_src, input logic [3:0] code, input logic reg_dst,
                        input logic rw, mr, mw, m2r);
    bus.id_valid       = 1'b1;
    bus.id_rs          = rs;
    bus.id_rt          = rt;
    bus.id_rd          = rd;
    bus.id_read_data_1 = rd1;
    bus.id_read_data_2 = rd2;
    bus.id_imm         = imm;
    bus.id_alu_src     = alu_src;
    bus.id_alu_control = code;
    bus.id_reg_dst     = reg_dst;
    bus.id_reg_write   = rw;
    bus.id_mem_read    = mr;
    bus.id_mem_write   = mw;
    bus.id_mem_to_reg  = m2r;
  endtask

  task automatic no_fwd();
    bus.exmem_reg_write  = 1'b0;
    bus.exmem_dest       = 5'd0;
    bus.exmem_alu_result = 32'h0;
    bus.memwb_reg_write  = 1'b0;
    bus.memwb_dest       = 5'd0;
    bus.memwb_wb_data    = 32'h0;
  endtask

  // lw $5, 4($1) in ID
  task automatic id_lw5();
    set_id(5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 32'd4, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // add $8, $5, $2 in ID (depends on $5)
  task automatic id_add8();
    set_id(5'd5, 5'd2, 5'd8, 32'h11, 32'h22, 32'h0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.flush = 1'b0;
    no_fwd();
    set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with a valid writing instruction in ID
    step(); step();
    check("rst_ex_valid",  32'(bus.ex_valid),      32'd0);
    check("rst_reg_write", 32'(bus.ex_reg_write),  32'd0);
    check("rst_stall",     32'(bus.stall_id),      32'd0);
    check("rst_code",      32'(bus.control_input), 32'd0);

    // add $3,$1,$2
    reset = 1'b0;
    step();
    check("add_opA",  bus.read_data_1,        32'd5);
    check("add_opB",  bus.mux_alu_src,        32'd7);
    check("add_code", 32'(bus.control_input), 32'd2);
    check("add_dest", 32'(bus.ex_dest),       32'd3);

    // addi $4,$1,-1
    set_id(5'd1, 5'd4, 5'd0, 32'd5, 32'd9, 32'hFFFF_FFFF, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("addi_opB", bus.mux_alu_src,  32'hFFFF_FFFF);
    check("addi_dest", 32'(bus.ex_dest), 32'd4);

    // Forwarding priority on rs = 3, rt = 6
    set_id(5'd3, 5'd6, 5'd7, 32'hAA, 32'hBB, 32'h0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    bus.exmem_reg_write = 1'b1; bus.exmem_dest = 5'd3; bus.exmem_alu_result = 32'h10;
    bus.memwb_reg_write = 1'b1; bus.memwb_dest = 5'd3; bus.memwb_wb_data    = 32'h20;
    #1 check("fwd_exmem_wins", bus.read_data_1, 32'h10);
    check("fwd_b_none", bus.mux_alu_src, 32'hBB);
    bus.exmem_reg_write = 1'b0;
    #1 check("fwd_memwb", bus.read_data_1, 32'h20);
    bus.memwb_dest = 5'd6;
    #1 check("fwd_b_memwb", bus.ex_store_data, 32'h20);
    check("fwd_b_opB",   bus.mux_alu_src,   32'h20);

    // rs = 0 with both stages writing $0: no forwarding
    no_fwd();
    set_id(5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'h0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    bus.exmem_reg_write = 1'b1; bus.exmem_dest = 5'd0; bus.exmem_alu_result = 32'h10;
    bus.memwb_reg_write = 1'b1; bus.memwb_dest = 5'd0; bus.memwb_wb_data    = 32'h20;
    #1 check("fwd_r0_a", bus.read_data_1, 32'h55);
    check("fwd_r0_b", bus.mux_alu_src, 32'h66);
    no_fwd();

    // Load-use on $5
    id_lw5();
    step();
    id_add8();
    #1 check("lu_stall", 32'(bus.stall_id), 32'd1);
    step();
    check("lu_bubble_valid", 32'(bus.ex_valid),     32'd0);
    check("lu_bubble_rw",    32'(bus.ex_reg_write), 32'd0);
    check("lu_released",     32'(bus.stall_id),     32'd0);
    step();
    check("lu_load_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_load_dest",  32'(bus.ex_dest),  32'd8);

    // lw $0 never stalls
    set_id(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'd4, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_id(5'd0, 5'd2, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("lu_r0_stall", 32'(bus.stall_id), 32'd0);

    // Flush and stall together: one bubble, then the held ID instruction
    id_lw5();
    step();
    id_add8();
    #1 check("fs_stall", 32'(bus.stall_id), 32'd1);
    bus.flush = 1'b1;
    step();
    check("fs_bubble", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;
    step();
    check("fs_load_valid", 32'(bus.ex_valid), 32'd1);
    check("fs_load_dest",  32'(bus.ex_dest),  32'd8);

    // Reset during a stall
    id_lw5();
    step();
    id_add8();
    reset = 1'b1;
    step();
    check("rs_valid", 32'(bus.ex_valid),      32'd0);
    check("rs_dest",  32'(bus.ex_dest),       32'd0);
    check("rs_code",  32'(bus.control_input), 32'd0);
    reset = 1'b0;

    // id_valid = 0 suppresses write/mem control
    set_id(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.id_valid = 1'b0;
    step();
    check("inv_valid", 32'(bus.ex_valid),     32'd0);
    check("inv_rw",    32'(bus.ex_reg_write), 32'd0);
    check("inv_mr",    32'(bus.ex_mem_read),  32'd0);
    check("inv_mw",    32'(bus.ex_mem_write), 32'd0);
    check("inv_code",  32'(bus.control_input), 32'd7);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
